// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: pipeline, debug and memory-side signals of the data memory controller.
interface dmem_access_ctrl_if;
    logic        p_req, p_we, p_ack, p_err, stall;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    modport slave (
        input  p_req, p_we, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output p_rdata, p_ack, p_err, stall, d_rdata, d_ack, d_err,
               mem_addr, mem_wdata, mem_read, mem_write
    );
    modport master (
        output p_req, p_we, p_addr, p_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  p_rdata, p_ack, p_err, stall, d_rdata, d_ack, d_err,
               mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: arbitrates pipeline and debug ports onto the single-port data memory,
// sequencing fixed read/write latencies and raising the pipeline stall.
module dmem_access_ctrl #(
    parameter int READ_LAT    = 2,
    parameter int WRITE_LAT   = 1,
    parameter int STARVE_MAX  = 4,
    parameter int DEPTH_WORDS = 256
) (
    input logic               clk,
    input logic               rst,
    dmem_access_ctrl_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state, state_nx;
    logic [SW-1:0] starve_cnt;
    logic [7:0]  cnt;
    logic        gnt_d, we_r, err_r, done;
    logic [31:0] rdata_r;
    logic        req, sel_d, sel_we, sel_err;
    logic [31:0] sel_addr, sel_wdata;
    always_comb begin
        req       = bus.p_req | bus.d_req;
        sel_d     = bus.d_req & (~bus.p_req | (starve_cnt == SW'(STARVE_MAX)));
        sel_we    = sel_d ? bus.d_we : bus.p_we;
        sel_addr  = sel_d ? bus.d_addr : bus.p_addr;
        sel_wdata = sel_d ? bus.d_wdata : bus.p_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || ((sel_addr >> 2) >= 32'(DEPTH_WORDS));
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE   ? (req ? (sel_err ? DONE : ACCESS) : IDLE) :
                   state == ACCESS ? (cnt == 8'd0 ? DONE : ACCESS) : IDLE;
    end
    // Grant-time latch; strobes and mem_addr/mem_wdata are registered here too.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt    <= '0;
            cnt           <= '0;
            gnt_d         <= 1'b0;
            we_r          <= 1'b0;
            err_r         <= 1'b0;
            rdata_r       <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
        end else if (state == IDLE && req) begin
            gnt_d         <= sel_d;
            we_r          <= sel_we;
            err_r         <= sel_err;
            rdata_r       <= '0;
            cnt           <= sel_we ? 8'(WRITE_LAT - 1) : 8'(READ_LAT - 1);
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.mem_read  <= ~sel_err & ~sel_we;
            bus.mem_write <= ~sel_err & sel_we;
            starve_cnt    <= (sel_d || !bus.d_req) ? '0 :
                             (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + SW'(1);
        end else if (state == ACCESS) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd0) begin
                bus.mem_read  <= 1'b0;
                bus.mem_write <= 1'b0;
                if (!we_r) rdata_r <= bus.mem_rdata;
            end
        end
    end
    always_comb begin
        done        = state == DONE;
        bus.p_ack   = done & ~gnt_d;
        bus.d_ack   = done & gnt_d;
        bus.p_err   = done & ~gnt_d & err_r;
        bus.d_err   = done & gnt_d & err_r;
        bus.p_rdata = (done & ~gnt_d) ? rdata_r : '0;
        bus.d_rdata = (done & gnt_d) ? rdata_r : '0;
        bus.stall   = bus.p_req & ~(done & ~gnt_d);
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed and randomized checks of dmem_access_ctrl against a
// transaction-level reference (word array, starvation counter, fixed latencies).
module tb_dmem_access_ctrl;
    localparam int RL = 2, WL = 1, SMAX = 4, DEPTH = 256;
    logic clk, rst, mem_init;
    int   n_chk, n_fail, sm;
    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] seq;
    dmem_access_ctrl_if bus();
    dmem_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // Memory slave: combinational read, write committed at each strobed edge.
    always @(posedge clk) begin
        if (mem_init) for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i);
        else if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[9:2]] : 32'h0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_quiet(input string tag);
        chk({tag, "_ctrl"}, 32'({bus.p_ack, bus.d_ack, bus.p_err, bus.d_err, bus.mem_read, bus.mem_write}), 32'h0);
        chk({tag, "_data"}, bus.p_rdata | bus.d_rdata | bus.mem_addr | bus.mem_wdata, 32'h0);
    endtask
    task automatic do_reset();
        rst = 1; mem_init = 1;
        bus.p_req = 0; bus.d_req = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);
        sm = 0;
        repeat (2) @(negedge clk);
        #1 chk_quiet("reset");
        rst = 0; mem_init = 0;
    endtask
    task automatic run_one(input bit dp, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bit err_e, seen;
        logic [31:0] rd_e;
        int lat_e, cyc, stl, rds, wrs;
        err_e = (addr % 4 != 0) || (addr / 4 >= DEPTH);
        rd_e  = (err_e || we) ? 32'h0 : ref_mem[addr[9:2]];
        lat_e = err_e ? 1 : (we ? WL + 1 : RL + 1);
        @(negedge clk);
        if (dp) begin bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; end
        else    begin bus.p_req = 1; bus.p_we = we; bus.p_addr = addr; bus.p_wdata = wdata; end
        cyc = 0; stl = 0; rds = 0; wrs = 0; seen = 0;
        while (!seen && cyc <= 20) begin
            #1;
            if (dp ? bus.d_ack : bus.p_ack) seen = 1;
            else begin
                stl += int'(bus.stall);
                rds += int'(bus.mem_read);
                wrs += int'(bus.mem_write);
                if (bus.mem_read || bus.mem_write) chk("mem_addr", bus.mem_addr, addr);
                if (bus.mem_write) chk("mem_wdata", bus.mem_wdata, wdata);
                @(negedge clk);
                cyc++;
            end
        end
        chk("ack_seen", 32'(seen), 32'h1);
        chk("latency", cyc, lat_e);
        chk("err", 32'(dp ? bus.d_err : bus.p_err), 32'(err_e));
        chk("rdata", dp ? bus.d_rdata : bus.p_rdata, rd_e);
        chk("other_ack", 32'(dp ? bus.p_ack : bus.d_ack), 32'h0);
        chk("stall_at_ack", 32'(bus.stall), 32'h0);
        chk("stall_cycles", stl, dp ? 0 : lat_e);
        chk("read_cycles", rds, (!err_e && !we) ? RL : 0);
        chk("write_cycles", wrs, (!err_e && we) ? WL : 0);
        if (we && !err_e) ref_mem[addr[9:2]] = wdata;
        sm = 0;
        @(negedge clk);
        bus.p_req = 0; bus.d_req = 0;
    endtask
    // Both ports issue back-to-back loads; each drops its request once its count is served.
    task automatic run_both(input int pn, input int dn, input logic [31:0] pa, input logic [31:0] da);
        int cyc, last;
        bit exp_d, first;
        cyc = 0; last = 0; first = 1; seq = 0;
        @(negedge clk);
        bus.p_we = 0; bus.d_we = 0; bus.p_addr = pa; bus.d_addr = da;
        bus.p_req = pn > 0; bus.d_req = dn > 0;
        while ((pn > 0 || dn > 0) && cyc < 200) begin
            #1;
            if (bus.p_ack || bus.d_ack) begin
                exp_d = dn > 0 && (pn == 0 || sm == SMAX);
                chk("arb_d", 32'(bus.d_ack), 32'(exp_d));
                chk("arb_p", 32'(bus.p_ack), 32'(!exp_d));
                chk("both_rdata", bus.p_rdata | bus.d_rdata, exp_d ? ref_mem[da[9:2]] : ref_mem[pa[9:2]]);
                chk("ack_gap", cyc - last, first ? RL + 1 : RL + 2);
                seq = {seq[30:0], exp_d};
                if (exp_d) begin dn--; sm = 0; end
                else begin pn--; sm = dn > 0 ? (sm < SMAX ? sm + 1 : SMAX) : 0; end
                last = cyc; first = 0;
            end
            @(negedge clk);
            cyc++;
            bus.p_req = pn > 0; bus.d_req = dn > 0;
        end
        chk("both_done", 32'(pn + dn), 32'h0);
        bus.p_req = 0; bus.d_req = 0;
    endtask
    initial begin
        clk = 0; rst = 1; mem_init = 1; n_chk = 0; n_fail = 0;
        bus.p_req = 0; bus.p_we = 0; bus.p_addr = 0; bus.p_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        do_reset();
        run_one(0, 0, 32'h40, 32'h0);
        run_one(0, 1, 32'h80, 32'hDEADBEEF);
        run_one(0, 0, 32'h80, 32'h0);
        run_both(8, 2, 32'h10, 32'h20);
        chk("grant_seq", seq, 32'b0000100001);
        run_one(1, 0, 32'h402, 32'h0);
        run_one(0, 0, 32'h400, 32'h0);
        do_reset();
        run_both(1, 1, 32'h44, 32'h48);
        chk("reset_grant_seq", seq, 32'b01);
        // Reset lands in the first ACCESS cycle of a load.
        @(negedge clk);
        bus.p_req = 1; bus.p_we = 0; bus.p_addr = 32'h0C;
        @(negedge clk);
        #1 chk("mid_read", 32'(bus.mem_read), 32'h1);
        rst = 1; bus.p_req = 0;
        @(negedge clk);
        #1 chk_quiet("mid_rst");
        bus.p_req = 1;
        #1 chk("stall_in_rst", 32'(bus.stall), 32'h1);
        @(negedge clk);
        #1 chk_quiet("held_rst");
        rst = 0; bus.p_req = 0;
        run_one(0, 0, 32'h0C, 32'h0);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int k;
            k = $urandom_range(0, 3);
            a = k < 2 ? {22'b0, 8'($urandom), 2'b00} :
                k == 2 ? {22'b0, 8'($urandom), 2'($urandom_range(1, 3))} :
                ($urandom | 32'h400) & 32'hFFFF_FFFC;
            run_one(1'($urandom), 1'($urandom), a, $urandom);
        end
        for (int i = 0; i < 5; i++)
            run_both($urandom_range(1, 4), $urandom_range(0, 4),
                     {22'b0, 8'($urandom), 2'b00}, {22'b0, 8'($urandom), 2'b00});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
